// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the pong ball renderer.
//   - ball_state_t : ball FSM encoding (SERVE, MOVE, MISS)
//   - COLOR_*      : RGB332 colour constants {R[2:0], G[2:0], B[1:0]}
//   - DEF_*        : default geometry / timing used as parameter defaults
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_MOVE  = 2'd1,
    ST_MISS  = 2'd2
  } ball_state_t;

  localparam logic [7:0] COLOR_WHITE  = 8'hFF;
  localparam logic [7:0] COLOR_PADDLE = 8'h1C;  // green = 7, red/blue = 0
  localparam logic [7:0] COLOR_SCORE  = 8'hE0;  // red = 7, green/blue = 0
  localparam logic [7:0] COLOR_BLACK  = 8'h00;

  localparam int DEF_RES_SIZE      = 10;
  localparam int DEF_BALL_SIZE     = 8;
  localparam int DEF_PADDLE_X      = 16;
  localparam int DEF_PADDLE_WIDTH  = 8;
  localparam int DEF_PADDLE_HEIGHT = 48;
  localparam int DEF_BALL_STEP     = 2;
  localparam int DEF_PADDLE_STEP   = 4;
  localparam int DEF_SERVE_FRAMES  = 60;

  // Score bar: rows 0..SCORE_ROWS-1, SCORE_UNIT pixels per miss.
  localparam int SCORE_ROWS       = 4;
  localparam int SCORE_UNIT_SHIFT = 3;

endpackage

// File: rtl/pong_rect_hit.sv
// pong_rect_hit: combinational point-in-rectangle test.
//   px, py : point under test
//   rx, ry : rectangle top-left corner
//   rw, rh : rectangle width / height (zero width or height never hits)
//   hit    : 1 when rx <= px < rx+rw and ry <= py < ry+rh
// W must leave headroom so rx+rw and ry+rh do not wrap.
module pong_rect_hit #(
  parameter int W = 11
) (
  input  logic [W-1:0] px,
  input  logic [W-1:0] py,
  input  logic [W-1:0] rx,
  input  logic [W-1:0] ry,
  input  logic [W-1:0] rw,
  input  logic [W-1:0] rh,
  output logic         hit
);

  always_comb begin
    hit = (px >= rx) && (px < rx + rw) && (py >= ry) && (py < ry + rh);
  end

endmodule

// File: rtl/pong_ball_renderer.sv
// pong_ball_renderer: single-player pong game logic plus pixel renderer that
// sits behind a CRT controller. Motion advances once per frame (falling edge
// of vsync); colour is produced one clock after the scan coordinate.
//
// Ports
//   Clock, Reset             : system clock, synchronous active-high reset
//   Xresolution, Yresolution : active video size
//   xpos, ypos               : current scan coordinate
//   hsync, vsync             : active-low syncs from the CRT controller
//   PaddleUp, PaddleDown     : debounced, level-sensitive buttons
//   Red, Green, Blue         : registered RGB332 pixel colour
//   hsyncOut, vsyncOut       : syncs delayed one clock to match the colour
//   Miss                     : one-cycle pulse when the ball passes the paddle
//   MissCount                : (PONG_SCORE_EN only) saturating miss counter
//   dbg_*                    : ball FSM state, positions and directions
//
// Build option: define PONG_SCORE_EN to add MissCount and the red score bar.
module pong_ball_renderer
  import pong_pkg::*;
#(
  parameter int ResolutionSize = DEF_RES_SIZE,
  parameter int BallSize       = DEF_BALL_SIZE,
  parameter int PaddleX        = DEF_PADDLE_X,
  parameter int PaddleWidth    = DEF_PADDLE_WIDTH,
  parameter int PaddleHeight   = DEF_PADDLE_HEIGHT,
  parameter int BallStep       = DEF_BALL_STEP,
  parameter int PaddleStep     = DEF_PADDLE_STEP,
  parameter int ServeFrames    = DEF_SERVE_FRAMES
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [ResolutionSize-1:0] Xresolution,
  input  logic [ResolutionSize-1:0] Yresolution,
  input  logic [ResolutionSize-1:0] xpos,
  input  logic [ResolutionSize-1:0] ypos,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      PaddleUp,
  input  logic                      PaddleDown,
  output logic [2:0]                Red,
  output logic [2:0]                Green,
  output logic [1:0]                Blue,
  output logic                      hsyncOut,
  output logic                      vsyncOut,
  output logic                      Miss,
`ifdef PONG_SCORE_EN
  output logic [3:0]                MissCount,
`endif
  output ball_state_t               dbg_state,
  output logic [ResolutionSize-1:0] dbg_ball_x,
  output logic [ResolutionSize-1:0] dbg_ball_y,
  output logic [ResolutionSize-1:0] dbg_paddle_y,
  output logic                      dbg_dir_x,
  output logic                      dbg_dir_y
);

  localparam int W    = ResolutionSize;
  localparam int WE   = ResolutionSize + 1;  // one spare bit so no compare wraps
  localparam int CntW = $clog2(ServeFrames + 1);

  localparam logic [WE-1:0]   BALL_E     = WE'(BallSize);
  localparam logic [WE-1:0]   BSTEP_E    = WE'(BallStep);
  localparam logic [WE-1:0]   PSTEP_E    = WE'(PaddleStep);
  localparam logic [WE-1:0]   PX_E       = WE'(PaddleX);
  localparam logic [WE-1:0]   PW_E       = WE'(PaddleWidth);
  localparam logic [WE-1:0]   PH_E       = WE'(PaddleHeight);
  localparam logic [CntW-1:0] SERVE_LAST = CntW'(ServeFrames - 1);

  // ---------------- state ----------------
  ball_state_t   state_q, state_d;
  logic [CntW-1:0] serve_cnt_q, serve_cnt_d;
  logic [WE-1:0] ball_x_q, ball_x_d;
  logic [WE-1:0] ball_y_q, ball_y_d;
  logic [WE-1:0] paddle_y_q, paddle_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic [7:0]    colour_q, colour_d;
  logic          hsync_q;
  // vsync_q is both the aligned vsyncOut and the "previous vsync" used to
  // detect the frame edge; both reset to 1 and follow vsync by one clock.
  logic          vsync_q;

  // ---------------- derived geometry ----------------
  logic [WE-1:0] x_res_e, y_res_e;
  logic [WE-1:0] ball_x_max, ball_y_max, paddle_y_max;
  logic [WE-1:0] ball_x_ctr, ball_y_ctr, paddle_y_ctr;

  always_comb begin
    x_res_e      = {1'b0, Xresolution};
    y_res_e      = {1'b0, Yresolution};
    ball_x_max   = x_res_e - BALL_E;
    ball_y_max   = y_res_e - BALL_E;
    paddle_y_max = y_res_e - PH_E;
    ball_x_ctr   = ball_x_max >> 1;
    ball_y_ctr   = ball_y_max >> 1;
    paddle_y_ctr = paddle_y_max >> 1;
  end

  logic frame_tick;
  always_comb begin
    frame_tick = vsync_q & ~vsync;
  end

  // ---------------- collision evaluation (pre-move) ----------------
  logic wall_right, wall_top, wall_bottom, paddle_hit, ball_miss;
  logic new_dir_x, new_dir_y;
  logic [WE-1:0] moved_x, moved_y;

  always_comb begin
    wall_right  = (ball_x_q + BALL_E + BSTEP_E) >= x_res_e;
    wall_top    = !dir_y_q && (ball_y_q < BSTEP_E);
    wall_bottom = (ball_y_q + BALL_E + BSTEP_E) >= y_res_e;
    paddle_hit  = !dir_x_q
                  && (ball_x_q <= PX_E + PW_E)
                  && (ball_x_q + BALL_E > PX_E)
                  && (ball_y_q < paddle_y_q + PH_E)
                  && (ball_y_q + BALL_E > paddle_y_q);
    ball_miss   = !dir_x_q && (ball_x_q < BSTEP_E) && !paddle_hit;

    // Axes are resolved independently, so a corner flips both.
    new_dir_x = dir_x_q;
    if (wall_right) new_dir_x = 1'b0;
    if (paddle_hit) new_dir_x = 1'b1;
    new_dir_y = dir_y_q;
    if (wall_top)    new_dir_y = 1'b1;
    if (wall_bottom) new_dir_y = 1'b0;

    // Step in the new direction, clamped to the legal range.
    if (new_dir_x) begin
      moved_x = (ball_x_q + BSTEP_E > ball_x_max) ? ball_x_max : ball_x_q + BSTEP_E;
    end else begin
      moved_x = (ball_x_q < BSTEP_E) ? '0 : ball_x_q - BSTEP_E;
    end
    if (new_dir_y) begin
      moved_y = (ball_y_q + BSTEP_E > ball_y_max) ? ball_y_max : ball_y_q + BSTEP_E;
    end else begin
      moved_y = (ball_y_q < BSTEP_E) ? '0 : ball_y_q - BSTEP_E;
    end
  end

  // ---------------- ball FSM next state ----------------
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    unique case (state_q)
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d = ST_MOVE;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_MOVE: begin
        if (frame_tick) begin
          dir_x_d = new_dir_x;
          dir_y_d = new_dir_y;
          if (ball_miss) begin
            state_d = ST_MISS;
          end else begin
            ball_x_d = moved_x;
            ball_y_d = moved_y;
          end
        end
      end
      ST_MISS: begin
        state_d     = ST_SERVE;
        serve_cnt_d = '0;
        ball_x_d    = ball_x_ctr;
        ball_y_d    = ball_y_ctr;
      end
      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  // ---------------- paddle next state ----------------
  always_comb begin
    paddle_y_d = paddle_y_q;
    if (frame_tick && PaddleUp && !PaddleDown) begin
      paddle_y_d = (paddle_y_q < PSTEP_E) ? '0 : paddle_y_q - PSTEP_E;
    end else if (frame_tick && PaddleDown && !PaddleUp) begin
      paddle_y_d = (paddle_y_q + PSTEP_E > paddle_y_max) ? paddle_y_max
                                                         : paddle_y_q + PSTEP_E;
    end
  end

  // ---------------- optional miss counter ----------------
  logic [WE-1:0] score_w;
`ifdef PONG_SCORE_EN
  logic [3:0] miss_cnt_q, miss_cnt_d;
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_MISS && miss_cnt_q != 4'd15) begin
      miss_cnt_d = miss_cnt_q + 4'd1;
    end
    score_w = WE'(miss_cnt_q) << SCORE_UNIT_SHIFT;
  end
  always_ff @(posedge Clock) begin
    if (Reset) miss_cnt_q <= '0;
    else       miss_cnt_q <= miss_cnt_d;
  end
  assign MissCount = miss_cnt_q;
`else
  always_comb begin
    score_w = '0;
  end
`endif

  // ---------------- draw ----------------
  logic [WE-1:0] x_pos_e, y_pos_e;
  logic active, ball_px, paddle_px, score_px;

  always_comb begin
    x_pos_e = {1'b0, xpos};
    y_pos_e = {1'b0, ypos};
    active  = (xpos < Xresolution) && (ypos < Yresolution);
  end

  pong_rect_hit #(.W(WE)) u_ball_hit (
    .px(x_pos_e), .py(y_pos_e), .rx(ball_x_q), .ry(ball_y_q),
    .rw(BALL_E), .rh(BALL_E), .hit(ball_px)
  );

  pong_rect_hit #(.W(WE)) u_paddle_hit (
    .px(x_pos_e), .py(y_pos_e), .rx(PX_E), .ry(paddle_y_q),
    .rw(PW_E), .rh(PH_E), .hit(paddle_px)
  );

  pong_rect_hit #(.W(WE)) u_score_hit (
    .px(x_pos_e), .py(y_pos_e), .rx('0), .ry('0),
    .rw(score_w), .rh(WE'(SCORE_ROWS)), .hit(score_px)
  );

  always_comb begin
    colour_d = COLOR_BLACK;
    if (active) begin
      if (ball_px)        colour_d = COLOR_WHITE;
      else if (score_px)  colour_d = COLOR_SCORE;
      else if (paddle_px) colour_d = COLOR_PADDLE;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_SERVE;
      serve_cnt_q <= '0;
      ball_x_q    <= ball_x_ctr;
      ball_y_q    <= ball_y_ctr;
      paddle_y_q  <= paddle_y_ctr;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      colour_q    <= COLOR_BLACK;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      paddle_y_q  <= paddle_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      colour_q    <= colour_d;
      hsync_q     <= hsync;
      vsync_q     <= vsync;
    end
  end

  // ---------------- outputs ----------------
  // A reset raised during the MISS cycle suppresses the pulse immediately.
  assign Miss         = (state_q == ST_MISS) && !Reset;
  assign Red          = colour_q[7:5];
  assign Green        = colour_q[4:2];
  assign Blue         = colour_q[1:0];
  assign hsyncOut     = hsync_q;
  assign vsyncOut     = vsync_q;
  assign dbg_state    = state_q;
  assign dbg_ball_x   = ball_x_q[W-1:0];
  assign dbg_ball_y   = ball_y_q[W-1:0];
  assign dbg_paddle_y = paddle_y_q[W-1:0];
  assign dbg_dir_x    = dir_x_q;
  assign dbg_dir_y    = dir_y_q;

endmodule

// File: tb/tb_pong_ball_renderer.sv
// tb_pong_ball_renderer: self-checking bench for pong_ball_renderer at the
// default parameters with a 640x480 screen. Frames are compressed: the bench
// drives vsync low for one clock to make each frame tick. A game-level model
// (plain integers) tracks ball, paddle and serve state per frame.
module tb_pong_ball_renderer;
  import pong_pkg::*;

  localparam int XRES  = 640;
  localparam int YRES  = 480;
  localparam int BSZ   = 8;
  localparam int PADX  = 16;
  localparam int PADW  = 8;
  localparam int PADH  = 48;
  localparam int BSTEP = 2;
  localparam int PSTEP = 4;
  localparam int SERVE = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset;
  logic [9:0] Xresolution, Yresolution, xpos, ypos;
  logic       hsync, vsync, PaddleUp, PaddleDown;
  logic [2:0] Red, Green;
  logic [1:0] Blue;
  logic       hsyncOut, vsyncOut, Miss;
  ball_state_t dbg_state;
  logic [9:0] dbg_ball_x, dbg_ball_y, dbg_paddle_y;
  logic       dbg_dir_x, dbg_dir_y;
`ifdef PONG_SCORE_EN
  logic [3:0] miss_count;
`endif

  pong_ball_renderer dut (
    .Clock(clk), .Reset(Reset),
    .Xresolution(Xresolution), .Yresolution(Yresolution),
    .xpos(xpos), .ypos(ypos), .hsync(hsync), .vsync(vsync),
    .PaddleUp(PaddleUp), .PaddleDown(PaddleDown),
    .Red(Red), .Green(Green), .Blue(Blue),
    .hsyncOut(hsyncOut), .vsyncOut(vsyncOut), .Miss(Miss),
`ifdef PONG_SCORE_EN
    .MissCount(miss_count),
`endif
    .dbg_state(dbg_state), .dbg_ball_x(dbg_ball_x), .dbg_ball_y(dbg_ball_y),
    .dbg_paddle_y(dbg_paddle_y), .dbg_dir_x(dbg_dir_x), .dbg_dir_y(dbg_dir_y)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int m_serving, m_cnt, m_bx, m_by, m_py, m_dx, m_dy;
  int n_hits = 0, n_misses = 0;

  task automatic model_reset();
    m_serving = 1; m_cnt = 0;
    m_bx = (XRES - BSZ) / 2; m_by = (YRES - BSZ) / 2;
    m_py = (YRES - PADH) / 2;
    m_dx = 1; m_dy = 1;
  endtask

  // One frame of play; reports whether the ball was lost this frame.
  task automatic model_tick(input bit up, input bit down, output bit missed);
    bit hit;
    int ndx, ndy;
    missed = 0;
    if (m_serving) begin
      m_cnt++;
      if (m_cnt == SERVE) begin
        m_serving = 0; m_dx = 1; m_dy = 1;
      end
    end else begin
      hit = (m_dx == 0) && (m_bx <= PADX + PADW) && (m_bx + BSZ > PADX) &&
            (m_by < m_py + PADH) && (m_by + BSZ > m_py);
      if (m_dx == 0 && m_bx < BSTEP && !hit) begin
        missed = 1; n_misses++;
        m_serving = 1; m_cnt = 0;
        m_bx = (XRES - BSZ) / 2; m_by = (YRES - BSZ) / 2;
      end else begin
        if (hit) n_hits++;
        ndx = m_dx; ndy = m_dy;
        if (m_bx + BSZ + BSTEP >= XRES) ndx = 0;
        if (hit) ndx = 1;
        if (m_dy == 0 && m_by < BSTEP) ndy = 1;
        if (m_by + BSZ + BSTEP >= YRES) ndy = 0;
        m_dx = ndx; m_dy = ndy;
        m_bx = ndx ? m_bx + BSTEP : m_bx - BSTEP;
        m_by = ndy ? m_by + BSTEP : m_by - BSTEP;
        if (m_bx < 0) m_bx = 0;
        if (m_bx > XRES - BSZ) m_bx = XRES - BSZ;
        if (m_by < 0) m_by = 0;
        if (m_by > YRES - BSZ) m_by = YRES - BSZ;
      end
    end
    if (up && !down)  m_py = (m_py - PSTEP < 0) ? 0 : m_py - PSTEP;
    if (down && !up)  m_py = (m_py + PSTEP > YRES - PADH) ? YRES - PADH : m_py + PSTEP;
  endtask

  function automatic logic [7:0] model_pixel(input int x, input int y);
    if (x >= XRES || y >= YRES) return 8'h00;
    if (x >= m_bx && x < m_bx + BSZ && y >= m_by && y < m_by + BSZ) return 8'hFF;
    if (x >= PADX && x < PADX + PADW && y >= m_py && y < m_py + PADH) return 8'h1C;
    return 8'h00;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_ball_x"}, dbg_ball_x, m_bx);
    check({tag, "_ball_y"}, dbg_ball_y, m_by);
    check({tag, "_paddle_y"}, dbg_paddle_y, m_py);
    check({tag, "_state"}, int'(dbg_state), m_serving ? int'(ST_SERVE) : int'(ST_MOVE));
    if (!m_serving) begin
      check({tag, "_dir_x"}, dbg_dir_x, m_dx);
      check({tag, "_dir_y"}, dbg_dir_y, m_dy);
    end
    check({tag, "_x_in_range"}, int'(dbg_ball_x <= 10'(XRES - BSZ)), 1);
  endtask

  // ---------------- drivers ----------------
  // One frame tick: vsync low for one clock. Optionally assert Reset during
  // the MISS cycle if the model says the ball is lost on this tick.
  task automatic do_tick(input bit up, input bit down, input bit rst_on_miss,
                         output bit missed);
    bit m;
    @(negedge clk);
    PaddleUp = up; PaddleDown = down; vsync = 1'b0;
    model_tick(up, down, m);
    missed = m;
    @(negedge clk);
    vsync = 1'b1;
    check("vsync_out_low", vsyncOut, 0);
    if (m && rst_on_miss) begin
      Reset = 1'b1;
      #1;
      check("miss_suppressed_by_reset", Miss, 0);
      @(negedge clk);
      Reset = 1'b0;
      model_reset();
      check("miss_after_reset", Miss, 0);
      check_state("reset_in_miss");
    end else begin
      check("miss_pulse", Miss, int'(m));
      @(negedge clk);
      check("miss_width", Miss, 0);
      check_state("tick");
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ball_x"}, dbg_ball_x, 316);
    check({tag, "_ball_y"}, dbg_ball_y, 236);
    check({tag, "_paddle_y"}, dbg_paddle_y, 216);
    check({tag, "_state"}, int'(dbg_state), int'(ST_SERVE));
    check({tag, "_colour"}, {Red, Green, Blue}, 0);
    check({tag, "_hsync_out"}, hsyncOut, 1);
    check({tag, "_vsync_out"}, vsyncOut, 1);
    check({tag, "_miss"}, Miss, 0);
  endtask

  // ---------------- draw vectors ----------------
  typedef struct {
    int         x;
    int         y;
    bit         hs;
    logic [7:0] col;
  } draw_vec_t;

  draw_vec_t dv[14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit missed, up, dn;
    int mode, x, y, sel;
    logic [7:0] prev_col;
    bit prev_hs;

    // Draw table against the reset position: ball 316..323 x 236..243,
    // paddle 16..23 x 216..263.
    dv[0]  = '{320, 240, 1'b1, 8'hFF};
    dv[1]  = '{700, 240, 1'b1, 8'h00};
    dv[2]  = '{316, 236, 1'b0, 8'hFF};
    dv[3]  = '{323, 243, 1'b1, 8'hFF};
    dv[4]  = '{324, 243, 1'b1, 8'h00};
    dv[5]  = '{16,  216, 1'b0, 8'h1C};
    dv[6]  = '{23,  263, 1'b1, 8'h1C};
    dv[7]  = '{24,  263, 1'b1, 8'h00};
    dv[8]  = '{15,  240, 1'b0, 8'h00};
    dv[9]  = '{20,  264, 1'b1, 8'h00};
    dv[10] = '{320, 480, 1'b1, 8'h00};
    dv[11] = '{639, 479, 1'b0, 8'h00};
    dv[12] = '{0,   0,   1'b1, 8'h00};
    dv[13] = '{18,  215, 1'b0, 8'h00};

    Reset = 1'b1; Xresolution = 10'(XRES); Yresolution = 10'(YRES);
    xpos = '0; ypos = '0; hsync = 1'b1; vsync = 1'b1;
    PaddleUp = 1'b0; PaddleDown = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    Reset = 1'b0;
    model_reset();

    // Draw table: apply on a falling edge, expect the colour one clock later
    // and not before.
    prev_col = 8'h00; prev_hs = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      xpos = 10'(dv[i].x); ypos = 10'(dv[i].y); hsync = dv[i].hs;
      #1;
      check("draw_hold_colour", {Red, Green, Blue}, prev_col);
      check("draw_hold_hsync", hsyncOut, prev_hs);
      @(negedge clk);
      check($sformatf("draw_colour_%0d", i), {Red, Green, Blue}, dv[i].col);
      check($sformatf("draw_hsync_%0d", i), hsyncOut, dv[i].hs);
      prev_col = dv[i].col; prev_hs = dv[i].hs;
    end
    hsync = 1'b1;

    // Serve with PaddleUp held: paddle saturates at 0, MOVE on the 60th tick.
    for (int i = 0; i < SERVE; i++) begin
      do_tick(1'b1, 1'b0, 1'b0, missed);
      if (i == SERVE - 2) check("still_serving_59", int'(dbg_state), int'(ST_SERVE));
    end
    check("serve_done_state", int'(dbg_state), int'(ST_MOVE));
    check("paddle_top", dbg_paddle_y, 0);
    check("ball_x_at_launch", dbg_ball_x, 316);
    do_tick(1'b1, 1'b1, 1'b0, missed);
    check("first_move_x", dbg_ball_x, 318);
    check("first_move_y", dbg_ball_y, 238);
    check("both_buttons_hold", dbg_paddle_y, 0);

    // Randomised play: tracking, evasive and random paddle phases.
    for (int t = 0; t < 2400; t++) begin
      mode = (t / 200) % 3;
      up = 1'b0; dn = 1'b0;
      if (mode == 0) begin
        if (m_py + PADH / 2 < m_by + BSZ / 2 - 2) dn = 1'b1;
        else if (m_py + PADH / 2 > m_by + BSZ / 2 + 2) up = 1'b1;
      end else if (mode == 1) begin
        if (m_py + PADH / 2 <= m_by + BSZ / 2) up = 1'b1;
        else dn = 1'b1;
      end else begin
        up = 1'($urandom_range(0, 1));
        dn = 1'($urandom_range(0, 1));
      end
      do_tick(up, dn, 1'b0, missed);
    end
    $display("info: paddle hits %0d, misses %0d", n_hits, n_misses);

    // Random pixels around the current ball / paddle / screen.
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        x = m_bx - 2 + $urandom_range(0, 11); y = m_by - 2 + $urandom_range(0, 11);
      end else if (sel == 1) begin
        x = 14 + $urandom_range(0, 11); y = m_py - 2 + $urandom_range(0, 51);
      end else begin
        x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      @(negedge clk);
      xpos = 10'(x); ypos = 10'(y); hsync = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("rand_pixel_%0d_%0d", x, y), {Red, Green, Blue}, model_pixel(x, y));
      check("rand_hsync", hsyncOut, hsync);
    end
    hsync = 1'b1;

    // Evade the ball until it is lost, then reset during the MISS cycle.
    missed = 1'b0;
    for (int k = 0; k < 3000 && !missed; k++) begin
      up = (m_py + PADH / 2 <= m_by + BSZ / 2);
      do_tick(up, !up, 1'b1, missed);
    end
    check("miss_reached", int'(missed), 1);

    // Reset in the middle of a rally, coincident with a frame edge.
    for (int k = 0; k < SERVE + 5; k++) do_tick(1'b0, 1'b1, 1'b0, missed);
    check("rally_before_reset", int'(dbg_state), int'(ST_MOVE));
    @(negedge clk);
    vsync = 1'b0; Reset = 1'b1;
    @(negedge clk);
    vsync = 1'b1;
    check_reset_values("midframe_reset");
    Reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_state("after_midframe_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
